// File: rtl/img_win_ctrl.sv
// img_win_ctrl: loads a square image from ROM, applies 2x2 window commands
// around an operation point (px,py), and dumps the image to RAM on request.
// Ports:
//   clk, reset      - rising-edge clock, synchronous active-high reset
//   cmd, cmd_valid  - command code and its qualifier (taken only when idle)
//   busy            - high while commands are ignored
//   IROM_rd/A/Q     - ROM read port (data valid in the same cycle)
//   IRAM_valid/A/D  - RAM write port used by the Write dump
//   done            - one-cycle pulse after the last dump write
module img_win_ctrl #(
  parameter int unsigned SIDE_LOG2 = 3,
  parameter int unsigned DW        = 8,
  localparam int unsigned AW       = 2 * SIDE_LOG2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          busy,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [AW-1:0] IRAM_A,
  output logic [DW-1:0] IRAM_D,
  output logic          done
);

  localparam int unsigned SL   = SIDE_LOG2;
  localparam int unsigned NPIX = 1 << AW;
  localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);
  localparam logic [SL-1:0] CENTER = SL'(1 << (SL - 1));
  localparam logic [SL-1:0] PMIN   = SL'(1);
  localparam logic [SL-1:0] PMAX   = SL'((1 << SL) - 1);

  localparam logic [3:0] CMD_WRITE  = 4'd0;
  localparam logic [3:0] CMD_UP     = 4'd1;
  localparam logic [3:0] CMD_DOWN   = 4'd2;
  localparam logic [3:0] CMD_LEFT   = 4'd3;
  localparam logic [3:0] CMD_RIGHT  = 4'd4;
  localparam logic [3:0] CMD_MAX    = 4'd5;
  localparam logic [3:0] CMD_MIN    = 4'd6;
  localparam logic [3:0] CMD_AVG    = 4'd7;
  localparam logic [3:0] CMD_CCW    = 4'd8;
  localparam logic [3:0] CMD_CW     = 4'd9;
  localparam logic [3:0] CMD_MIRX   = 4'd10;
  localparam logic [3:0] CMD_MIRY   = 4'd11;
  localparam logic [3:0] CMD_RELOAD = 4'd12;
  localparam logic [3:0] CMD_CENTER = 4'd13;

  typedef enum logic [1:0] {LOAD, IDLE, EXEC, DUMP} state_t;

  state_t          state, state_d;
  logic [DW-1:0]   img [NPIX];
  logic [SL-1:0]   px, py;
  logic [3:0]      cmd_q;
  logic            accept;
  logic [AW-1:0]   a0, a1, a2, a3;
  logic [DW-1:0]   p0, p1, p2, p3;
  logic [DW-1:0]   n0, n1, n2, n3;
  logic [DW-1:0]   mx01, mx23, mx, mn01, mn23, mn;
  logic [DW+1:0]   sum;
  logic            win_we;

  assign accept = (state == IDLE) && cmd_valid && !busy;

  // Window addresses: address = {y, x}
  assign a0 = {py - PMIN, px - PMIN};
  assign a1 = {py - PMIN, px};
  assign a2 = {py, px - PMIN};
  assign a3 = {py, px};
  assign p0 = img[a0];
  assign p1 = img[a1];
  assign p2 = img[a2];
  assign p3 = img[a3];

  assign mx01 = (p0 > p1) ? p0 : p1;
  assign mx23 = (p2 > p3) ? p2 : p3;
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn01 = (p0 < p1) ? p0 : p1;
  assign mn23 = (p2 < p3) ? p2 : p3;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;
  assign sum  = (DW+2)'(p0) + (DW+2)'(p1) + (DW+2)'(p2) + (DW+2)'(p3);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= LOAD;
    else       state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      LOAD: if (IROM_A == LAST) state_d = IDLE;
      IDLE: if (accept) begin
        if (cmd == CMD_WRITE)       state_d = DUMP;
        else if (cmd == CMD_RELOAD) state_d = LOAD;
        else                        state_d = EXEC;
      end
      EXEC: state_d = IDLE;
      DUMP: if (IRAM_A == LAST) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // New window values; all taken from pre-command pixels
  always_comb begin
    win_we = 1'b1;
    n0 = p0;
    n1 = p1;
    n2 = p2;
    n3 = p3;
    case (cmd_q)
      CMD_MAX: begin n0 = mx; n1 = mx; n2 = mx; n3 = mx; end
      CMD_MIN: begin n0 = mn; n1 = mn; n2 = mn; n3 = mn; end
      CMD_AVG: begin
        n0 = DW'(sum >> 2);
        n1 = DW'(sum >> 2);
        n2 = DW'(sum >> 2);
        n3 = DW'(sum >> 2);
      end
      CMD_CCW:  begin n0 = p1; n1 = p3; n3 = p2; n2 = p0; end
      CMD_CW:   begin n0 = p2; n2 = p3; n3 = p1; n1 = p0; end
      CMD_MIRX: begin n0 = p2; n2 = p0; n1 = p3; n3 = p1; end
      CMD_MIRY: begin n0 = p1; n1 = p0; n2 = p3; n3 = p2; end
      default:  win_we = 1'b0;
    endcase
  end

  // Image buffer: filled during LOAD, modified by window commands, never cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == LOAD) begin
        img[IROM_A] <= IROM_Q;
      end else if (state == EXEC && win_we) begin
        img[a0] <= n0;
        img[a1] <= n1;
        img[a2] <= n2;
        img[a3] <= n3;
      end
    end
  end

  // Registered outputs, operation point and latched command
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b1;
      IROM_rd    <= 1'b1;
      IROM_A     <= '0;
      IRAM_valid <= 1'b0;
      IRAM_A     <= '0;
      IRAM_D     <= '0;
      done       <= 1'b0;
      px         <= CENTER;
      py         <= CENTER;
      cmd_q      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD: begin
          if (IROM_A == LAST) begin
            IROM_rd <= 1'b0;
            busy    <= 1'b0;
          end else begin
            IROM_A <= IROM_A + AW'(1);
          end
        end
        IDLE: begin
          if (accept) begin
            busy  <= 1'b1;
            cmd_q <= cmd;
            if (cmd == CMD_WRITE) begin
              IRAM_valid <= 1'b1;
              IRAM_A     <= '0;
              IRAM_D     <= img[0];
            end else if (cmd == CMD_RELOAD) begin
              IROM_rd <= 1'b1;
              IROM_A  <= '0;
              px      <= CENTER;
              py      <= CENTER;
            end
          end
        end
        EXEC: begin
          busy <= 1'b0;
          case (cmd_q)
            CMD_UP:     if (py != PMIN) py <= py - SL'(1);
            CMD_DOWN:   if (py != PMAX) py <= py + SL'(1);
            CMD_LEFT:   if (px != PMIN) px <= px - SL'(1);
            CMD_RIGHT:  if (px != PMAX) px <= px + SL'(1);
            CMD_CENTER: begin px <= CENTER; py <= CENTER; end
            default: ;
          endcase
        end
        DUMP: begin
          if (IRAM_A == LAST) begin
            IRAM_valid <= 1'b0;
            done       <= 1'b1;
            busy       <= 1'b0;
          end else begin
            IRAM_A <= IRAM_A + AW'(1);
            IRAM_D <= img[IRAM_A + AW'(1)];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
